imem_boot_loader: RTL and testbench

Boot-time sequencer for the 64-entry instruction memory. It receives a byte stream from a host link (UART/debug receiver) through a valid/ready handshake and assembles little-endian 32-bit words. It drives the memory's write port (write_enable/write_address/write_data) and holds the CPU fetch path in stall until a complete image is loaded. It sits between the host receiver and the instruction memory, and its cpu_hold output gates the PC/fetch stage.

---
 rtl/imem_pkg.sv | 27 ++
 rtl/imem_byte_packer.sv | 39 +++
 rtl/imem_boot_loader.sv | 134 +++++++++++++
 tb/tb_imem_boot_loader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and sizing for the instruction-memory boot loader.
// No logic; imported by the loader and its byte packer.
package imem_pkg;

   localparam int IMEM_DEPTH = 64;
   localparam int IMEM_AW    = 6;
   localparam int INSTR_W    = 32;
   localparam int IMEM_CNT_W = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HDR0  = 3'd1,
      HDR1  = 3'd2,
      DATA  = 3'd3,
      WRITE = 3'd4,
      CSUM  = 3'd5,
      DONE  = 3'd6,
      ERR   = 3'd7
   } state_t;

   // Little-endian word-count header as received from the host.
   typedef struct packed {
      logic [7:0] hi;
      logic [7:0] lo;
   } hdr_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs accepted bytes into little-endian 32-bit words; word_vld is a combinational
// pulse on the 4th byte so the word can be registered on that same edge. No backpressure.
module imem_byte_packer
   import imem_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               byte_vld,
   input  logic [7:0]         byte_dat,
   output logic               word_vld,
   output logic [INSTR_W-1:0] word_dat
);

   logic [1:0]  lane_q;
   logic [23:0] lo_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lane_q <= 2'd0;
         lo_q   <= 24'd0;
      end else if (clear) begin
         lane_q <= 2'd0;
      end else if (byte_vld) begin
         lane_q <= lane_q + 2'd1;
         case (lane_q)
            2'd0:    lo_q[7:0]   <= byte_dat;
            2'd1:    lo_q[15:8]  <= byte_dat;
            2'd2:    lo_q[23:16] <= byte_dat;
            default: ;
         endcase
      end
   end

   // The top lane bypasses storage and completes the word directly.
   assign word_vld = byte_vld && (lane_q == 2'd3);
   assign word_dat = {byte_dat, lo_q};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: header + LE words from host into instruction memory, holds CPU until done.
// Write one cycle after a word's 4th byte; in_ready low outside HDR0/HDR1/DATA/CSUM.
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_boot_loader
   import imem_pkg::*;
#(
   parameter int DEPTH = IMEM_DEPTH,
   parameter int CNT_W = IMEM_CNT_W
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        write_enable,
   output logic [31:0] write_address,
   output logic [31:0] write_data,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        load_error
);

   localparam int AW = $clog2(DEPTH);
   localparam int IW = AW + 1;

   state_t             state_q, state_d;
   hdr_t               count_q;
   logic [IW-1:0]      index_q;
   logic [AW-1:0]      addr_q;
   logic [INSTR_W-1:0] data_q;
   logic [INSTR_W-1:0] word_dat;
   logic               word_vld;
   logic               accept, hdr_lo_acc, hdr_hi_acc, data_acc;
   logic [CNT_W-1:0]   hdr_count, idx_next;

   assign in_ready   = state_q inside {HDR0, HDR1, DATA, CSUM};
   assign accept     = in_valid && in_ready;
   assign hdr_lo_acc = accept && (state_q == HDR0);
   assign hdr_hi_acc = accept && (state_q == HDR1);
   assign data_acc   = accept && (state_q == DATA);
   assign hdr_count  = CNT_W'({in_data, count_q.lo});
   assign idx_next   = CNT_W'(index_q) + CNT_W'(1);

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t FINISH = CSUM;
   logic [7:0] xor_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         xor_q <= 8'd0;
      else if (state_q == HDR0)
         xor_q <= 8'd0;
      else if (data_acc)
         xor_q <= xor_q ^ in_data;
   end
`else
   localparam state_t FINISH = DONE;
`endif

   imem_byte_packer u_packer (
      .clk      (clk),
      .reset    (reset),
      .clear    (hdr_hi_acc),
      .byte_vld (data_acc),
      .byte_dat (in_data),
      .word_vld (word_vld),
      .word_dat (word_dat)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (start) state_d = HDR0;
         HDR0:  if (accept) state_d = HDR1;
         HDR1: begin
            if (accept) begin
               if (hdr_count == '0)
                  state_d = FINISH;
               else if (hdr_count > CNT_W'(DEPTH))
                  state_d = ERR;
               else
                  state_d = DATA;
            end
         end
         DATA:  if (word_vld) state_d = WRITE;
         WRITE: state_d = (idx_next == CNT_W'(count_q)) ? FINISH : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM:  if (accept) state_d = (in_data == xor_q) ? DONE : ERR;
`endif
         DONE:  if (start) state_d = HDR0;
         ERR:   if (start) state_d = HDR0;
         default: state_d = IDLE;
      endcase
   end

   // Address/data latch on the 4th byte so they are stable throughout WRITE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         index_q <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         if (hdr_lo_acc)
            count_q.lo <= in_data;
         if (hdr_hi_acc) begin
            count_q.hi <= in_data;
            index_q    <= '0;
         end
         if (word_vld) begin
            addr_q <= index_q[AW-1:0];
            data_q <= word_dat;
         end
         if (state_q == WRITE)
            index_q <= index_q + IW'(1);
      end
   end

   assign write_enable  = (state_q == WRITE);
   assign write_address = {{(32-AW){1'b0}}, addr_q};
   assign write_data    = data_q;
   assign cpu_hold      = (state_q != DONE);
   assign load_done     = (state_q == DONE);
   assign load_error    = (state_q == ERR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: table-driven image loads, hand corner cases.
module tb_imem_boot_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready, write_enable, cpu_hold, load_done, load_error;
   logic [31:0] write_address, write_data;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_wr_cyc = -1;
   int   fall_cyc = -1;
   logic prev_hold = 1'b1;

   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [7:0]  tx_q[$];

   typedef struct {
      int   cnt;
      int   pct;
      int   exp_writes;
      logic exp_done;
      logic exp_err;
   } vec_t;
   vec_t vecs[7];

   imem_boot_loader dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ready      (in_ready),
      .write_enable  (write_enable),
      .write_address (write_address),
      .write_data    (write_data),
      .cpu_hold      (cpu_hold),
      .load_done     (load_done),
      .load_error    (load_error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (write_enable) begin
         wr_addr_q.push_back(write_address);
         wr_data_q.push_back(write_data);
         last_wr_cyc = cyc;
         chk("in_ready_during_write", {31'b0, in_ready}, 32'd0);
      end
      if (prev_hold && !cpu_hold)
         fall_cyc = cyc;
      prev_hold = cpu_hold;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int pct);
      bit acc = 1'b0;
      int guard = 0;
      while (!acc && guard < 400) begin
         @(negedge clk);
         in_valid = ($urandom_range(99) < pct);
         in_data  = in_valid ? b : 8'($urandom);
         #1;
         acc = in_valid && in_ready;
         guard++;
      end
      chk("byte_accepted", {31'b0, acc}, 32'd1);
   endtask

   task automatic send_all(input int pct);
      foreach (tx_q[i]) send_byte(tx_q[i], pct);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic begin_load();
      wr_addr_q.delete();
      wr_data_q.delete();
      fall_cyc = -1;
      pulse_start();
   endtask

   // Header, random little-endian words, and (with the feature) the XOR of all data bytes.
   task automatic build_image(input int cnt, input bit bad_csum);
      logic [31:0] w;
      logic [7:0]  x = 8'h00;
      int          nwords = (cnt <= 64) ? cnt : 0;
      tx_q.delete();
      tx_q.push_back(cnt[7:0]);
      tx_q.push_back(cnt[15:8]);
      for (int i = 0; i < nwords; i++) begin
         w = $urandom;
         for (int b = 0; b < 4; b++) begin
            tx_q.push_back(w[8*b +: 8]);
            x = x ^ w[8*b +: 8];
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (cnt <= 64) tx_q.push_back(bad_csum ? (x ^ 8'h01) : x);
`else
      if (bad_csum) tx_q.push_back(x);
`endif
   endtask

   // Reference: word i is bytes 2+4i..5+4i of the image, written at address i.
   task automatic check_writes(input string name, input int exp_n);
      int cnt = {16'd0, tx_q[1], tx_q[0]};
      chk({name, "_nwrites"}, wr_addr_q.size(), exp_n);
      if (cnt <= 64) begin
         for (int i = 0; i < cnt && i < wr_addr_q.size(); i++) begin
            chk({name, "_addr"}, wr_addr_q[i], i);
            chk({name, "_data"}, wr_data_q[i],
                {tx_q[5+4*i], tx_q[4+4*i], tx_q[3+4*i], tx_q[2+4*i]});
         end
      end
   endtask

   task automatic check_status(input string name, input logic done, input logic err);
      chk({name, "_load_done"},  {31'b0, load_done},  {31'b0, done});
      chk({name, "_load_error"}, {31'b0, load_error}, {31'b0, err});
      chk({name, "_cpu_hold"},   {31'b0, cpu_hold},   {31'b0, !done});
   endtask

   initial begin
      vecs[0] = '{cnt: 1,   pct: 100, exp_writes: 1,  exp_done: 1'b1, exp_err: 1'b0};
      vecs[1] = '{cnt: 3,   pct: 50,  exp_writes: 3,  exp_done: 1'b1, exp_err: 1'b0};
      vecs[2] = '{cnt: 0,   pct: 100, exp_writes: 0,  exp_done: 1'b1, exp_err: 1'b0};
      vecs[3] = '{cnt: 65,  pct: 100, exp_writes: 0,  exp_done: 1'b0, exp_err: 1'b1};
      vecs[4] = '{cnt: 64,  pct: 100, exp_writes: 64, exp_done: 1'b1, exp_err: 1'b0};
      vecs[5] = '{cnt: 300, pct: 70,  exp_writes: 0,  exp_done: 1'b0, exp_err: 1'b1};
      vecs[6] = '{cnt: 5,   pct: 30,  exp_writes: 5,  exp_done: 1'b1, exp_err: 1'b0};

      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_in_ready",      {31'b0, in_ready},     32'd0);
      chk("rst_write_enable",  {31'b0, write_enable}, 32'd0);
      chk("rst_write_address", write_address,         32'd0);
      chk("rst_write_data",    write_data,            32'd0);
      check_status("rst", 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      // Two-word image with known contents and hold-release timing.
      tx_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
      tx_q.push_back(8'h91);
`endif
      begin_load();
      send_all(100);
      chk("img2_nwrites", wr_addr_q.size(), 2);
      if (wr_addr_q.size() == 2) begin
         chk("img2_addr0", wr_addr_q[0], 32'd0);
         chk("img2_data0", wr_data_q[0], 32'h0000_0093);
         chk("img2_addr1", wr_addr_q[1], 32'd1);
         chk("img2_data1", wr_data_q[1], 32'h0010_0113);
      end
      check_status("img2", 1'b1, 1'b0);
`ifndef IMEM_LOADER_CHECKSUM_EN
      chk("img2_hold_fall_cycle", fall_cyc, last_wr_cyc + 1);
`endif

      // Restart from DONE must reassert hold on the next cycle.
      pulse_start();
      #1;
      chk("restart_cpu_hold",  {31'b0, cpu_hold},  32'd1);
      chk("restart_load_done", {31'b0, load_done}, 32'd0);
      chk("restart_in_ready",  {31'b0, in_ready},  32'd1);
      build_image(0, 1'b0);
      wr_addr_q.delete();
      wr_data_q.delete();
      send_all(100);
      check_writes("empty", 0);
      check_status("empty", 1'b1, 1'b0);

      for (int v = 0; v < 7; v++) begin
         build_image(vecs[v].cnt, 1'b0);
         begin_load();
         send_all(vecs[v].pct);
         check_writes($sformatf("vec%0d", v), vecs[v].exp_writes);
         check_status($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err);
      end

      // Bursty host valid while one known word is sent.
      tx_q = '{8'h01, 8'h00, 8'h93, 8'h81, 8'h20, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
      tx_q.push_back(8'h32);
`endif
      begin_load();
      send_all(50);
      chk("burst_nwrites", wr_addr_q.size(), 1);
      if (wr_addr_q.size() == 1) begin
         chk("burst_addr", wr_addr_q[0], 32'd0);
         chk("burst_data", wr_data_q[0], 32'h0020_8193);
      end
      check_status("burst", 1'b1, 1'b0);

      // Reset after six data bytes of a two-word image.
      build_image(2, 1'b0);
      begin_load();
      for (int i = 0; i < 8; i++) send_byte(tx_q[i], 100);
      @(negedge clk);
      in_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("midrst_cpu_hold",     {31'b0, cpu_hold},     32'd1);
      chk("midrst_load_done",    {31'b0, load_done},    32'd0);
      chk("midrst_in_ready",     {31'b0, in_ready},     32'd0);
      chk("midrst_write_enable", {31'b0, write_enable}, 32'd0);
      chk("midrst_nwrites",      wr_addr_q.size(),      1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'hA5;
      repeat (5) @(negedge clk);
      in_valid = 1'b0;
      chk("postrst_nwrites",  wr_addr_q.size(),  1);
      chk("postrst_cpu_hold", {31'b0, cpu_hold}, 32'd1);
      chk("postrst_in_ready", {31'b0, in_ready}, 32'd0);
      build_image(3, 1'b0);
      begin_load();
      send_all(60);
      check_writes("recover", 3);
      check_status("recover", 1'b1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      tx_q = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h93};
      begin_load();
      send_all(100);
      check_writes("csum_good", 1);
      check_status("csum_good", 1'b1, 1'b0);
      tx_q = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h92};
      begin_load();
      send_all(100);
      check_writes("csum_bad", 1);
      check_status("csum_bad", 1'b0, 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
